// File: rtl/ssd_display_driver_pkg.sv
// Shared constants for the seven-segment display driver: widths, segment codes,
// converter FSM encodings and the digit helpers used by both converter and scanner.
package ssd_display_driver_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int VALUE_W    = 13;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: any nibble >=5 would overflow past 9 after the shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ssd_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter, free-running IDLE -> SHIFT(13) -> COMMIT.
// bcd only changes on COMMIT, so consumers never see a half-converted value.
module bin2bcd_seq
   import ssd_display_driver_pkg::*;
(
   input  logic               clk,
   input  logic               Reset,
   input  logic [VALUE_W-1:0] bin,
   output logic [BCD_W-1:0]   bcd,
   output logic               done
);

   logic [1:0]               state_q, state_d;
   logic [VALUE_W-1:0]       sr_q, sr_d;
   logic [BCD_W-1:0]         acc_q, acc_d;
   logic [BCD_W-1:0]         bcd_q, bcd_d;
   logic [3:0]               iter_q, iter_d;
   logic                     done_q, done_d;
   logic [BCD_W-1:0]         adj;
   logic [BCD_W+VALUE_W-1:0] shifted;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      done_d  = 1'b0;
      adj     = bcd_adjust(acc_q);
      shifted = {adj, sr_q} << 1;
      case (state_q)
         ST_IDLE: begin
            sr_d    = bin;
            acc_d   = '0;
            iter_d  = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            acc_d  = shifted[BCD_W+VALUE_W-1:VALUE_W];
            sr_d   = shifted[VALUE_W-1:0];
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'(VALUE_W - 1)) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            bcd_d   = acc_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         done_q  <= done_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/ssd_display_driver.sv
// 4-digit common-anode display driver: converts the 13-bit debug value to BCD
// and scans one digit per DIGIT_PERIOD cycles with optional leading-zero blanking.
module ssd_display_driver
   import ssd_display_driver_pkg::*;
#(
   parameter int DIGIT_PERIOD = 100000,
   parameter bit BLANK_LZ     = 1'b1
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic [VALUE_W-1:0] value,
   output logic [3:0]         anode,
   output logic [6:0]         segments,
   output logic               conv_done
);

   localparam int CNT_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);

   logic [BCD_W-1:0] digits;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d, idx_nxt;
   logic [3:0]       anode_q, anode_d;
   logic [6:0]       segments_q, segments_d;
   logic [3:0]       blank;
   logic [3:0]       nxt_digit;

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .Reset (Reset),
      .bin   (value),
      .bcd   (digits),
      .done  (conv_done)
   );

   // The ones digit is never blanked so a zero value still shows '0'.
   always_comb begin
      blank = 4'b0000;
      if (BLANK_LZ) begin
         blank[3] = (digits[15:12] == 4'd0);
         blank[2] = blank[3] && (digits[11:8] == 4'd0);
         blank[1] = blank[2] && (digits[7:4] == 4'd0);
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      anode_d    = anode_q;
      segments_d = segments_q;
      idx_nxt    = idx_q + 2'd1;
      nxt_digit  = digits[4*idx_nxt +: 4];
      if (cnt_q == CNT_LAST) begin
         cnt_d      = '0;
         idx_d      = idx_nxt;
         anode_d    = ~(4'b0001 << idx_nxt);
         segments_d = blank[idx_nxt] ? SEG_BLANK : seg_decode(nxt_digit);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         anode_q    <= 4'b1111;
         segments_q <= SEG_BLANK;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         anode_q    <= anode_d;
         segments_q <= segments_d;
      end
   end

   assign anode    = anode_q;
   assign segments = segments_q;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed bench for ssd_display_driver with DIGIT_PERIOD=4; a second instance
// with BLANK_LZ=0 shares the stimulus so both blanking modes are observed together.
module tb_ssd_display_driver;

   logic        clk = 1'b0;
   logic        Reset;
   logic [12:0] value;
   logic [3:0]  anode, anode_nb;
   logic [6:0]  segments, segments_nb;
   logic        conv_done, conv_done_nb;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] cap_seg[4];
   logic [6:0] cap_seg_nb[4];
   int         cap_hold[4];
   bit         cap_ok;

   always #5 clk = ~clk;

   ssd_display_driver #(.DIGIT_PERIOD(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .Reset(Reset), .value(value),
      .anode(anode), .segments(segments), .conv_done(conv_done)
   );

   ssd_display_driver #(.DIGIT_PERIOD(4), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .Reset(Reset), .value(value),
      .anode(anode_nb), .segments(segments_nb), .conv_done(conv_done_nb)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Records one full scan starting at the first cycle of the ones digit.
   task automatic capture_scan();
      logic [3:0] prev;
      bit found;
      int k;
      cap_ok = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cap_seg[i]    = 7'bx;
         cap_seg_nb[i] = 7'bx;
         cap_hold[i]   = 0;
      end
      prev = anode;
      for (int c = 0; c < 40 && !found; c++) begin
         step(1);
         if (anode == 4'b1110 && prev != 4'b1110) found = 1'b1;
         else prev = anode;
      end
      if (!found) return;
      for (int c = 0; c < 16; c++) begin
         case (anode)
            4'b1110: k = 0;
            4'b1101: k = 1;
            4'b1011: k = 2;
            4'b0111: k = 3;
            default: k = -1;
         endcase
         if (k >= 0) begin
            cap_seg[k]    = segments;
            cap_seg_nb[k] = segments_nb;
            cap_hold[k]++;
         end
         if (c != 15) step(1);
      end
      cap_ok = 1'b1;
   endtask

   task automatic wait_done(output bit ok, output int cycles);
      ok = 1'b0;
      cycles = 0;
      for (int c = 1; c <= 40 && !ok; c++) begin
         step(1);
         if (conv_done) begin
            ok = 1'b1;
            cycles = c;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      value = 13'd1234;
      step(2);
      n_cmp++;
      if (anode !== 4'b1111 || segments !== 7'h7F || conv_done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_init: anode=%b seg=%h done=%b want 1111/7f/0", anode, segments, conv_done);
      end
      Reset = 1'b0;
      step(22);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         n_cmp++;
         if (anode !== 4'b1111 || segments !== 7'h7F || conv_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_scan[%0d]: anode=%b seg=%h done=%b want 1111/7f/0", i, anode, segments, conv_done);
         end
         n_cmp++;
         if (anode_nb !== 4'b1111 || segments_nb !== 7'h7F || conv_done_nb !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_scan_nb[%0d]: anode=%b seg=%h done=%b want 1111/7f/0", i, anode_nb, segments_nb, conv_done_nb);
         end
      end
   endtask

   task automatic test_1234();
      bit ok;
      int cyc;
      logic [6:0] exp_seg[4] = '{7'h19, 7'h30, 7'h24, 7'h79};
      value = 13'd1234;
      Reset = 1'b0;
      wait_done(ok, cyc);
      n_cmp++;
      if (!ok || cyc != 15) begin
         n_bad++;
         $display("FAIL latency_1234: conv_done after %0d cycles (seen=%0d) want 15", cyc, ok);
      end
      step(1);
      n_cmp++;
      if (conv_done !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse_width: conv_done=%b want 0 one cycle after pulse", conv_done);
      end
      capture_scan();
      n_cmp++;
      if (!cap_ok) begin
         n_bad++;
         $display("FAIL scan_1234_timeout: ones digit never lit, got anode=%b want 1110", anode);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (cap_seg[k] !== exp_seg[k] || cap_hold[k] != 4) begin
            n_bad++;
            $display("FAIL scan_1234 digit%0d: seg=%h hold=%0d want seg=%h hold=4", k, cap_seg[k], cap_hold[k], exp_seg[k]);
         end
      end
   endtask

   task automatic test_8191();
      logic [6:0] exp_seg[4] = '{7'h79, 7'h10, 7'h79, 7'h00};
      value = 13'd8191;
      step(35);
      capture_scan();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (!cap_ok || cap_seg[k] !== exp_seg[k]) begin
            n_bad++;
            $display("FAIL scan_8191 digit%0d: seg=%h want %h", k, cap_seg[k], exp_seg[k]);
         end
      end
   endtask

   task automatic test_blanking();
      logic [6:0] exp7[4]    = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
      logic [6:0] exp7_nb[4] = '{7'h78, 7'h40, 7'h40, 7'h40};
      logic [6:0] exp0[4]    = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
      logic [6:0] exp0_nb[4] = '{7'h40, 7'h40, 7'h40, 7'h40};
      value = 13'd7;
      step(35);
      capture_scan();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (!cap_ok || cap_seg[k] !== exp7[k]) begin
            n_bad++;
            $display("FAIL blank_7 digit%0d: seg=%h want %h", k, cap_seg[k], exp7[k]);
         end
         n_cmp++;
         if (!cap_ok || cap_seg_nb[k] !== exp7_nb[k]) begin
            n_bad++;
            $display("FAIL noblank_7 digit%0d: seg=%h want %h", k, cap_seg_nb[k], exp7_nb[k]);
         end
      end
      value = 13'd0;
      step(35);
      capture_scan();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (!cap_ok || cap_seg[k] !== exp0[k]) begin
            n_bad++;
            $display("FAIL blank_0 digit%0d: seg=%h want %h", k, cap_seg[k], exp0[k]);
         end
         n_cmp++;
         if (!cap_ok || cap_seg_nb[k] !== exp0_nb[k]) begin
            n_bad++;
            $display("FAIL noblank_0 digit%0d: seg=%h want %h", k, cap_seg_nb[k], exp0_nb[k]);
         end
      end
   endtask

   task automatic test_change_during_shift();
      bit ok;
      int cyc;
      int mixed;
      logic [6:0] exp_seg[4] = '{7'h00, 7'h78, 7'h02, 7'h12};
      value = 13'd1234;
      step(35);
      wait_done(ok, cyc);
      step(3);
      value = 13'd5678;
      mixed = 0;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         step(1);
         if (dut.u_bcd.bcd !== 16'h1234 && dut.u_bcd.bcd !== 16'h5678) mixed++;
         if (conv_done) ok = 1'b1;
      end
      n_cmp++;
      if (!ok || dut.u_bcd.bcd !== 16'h1234) begin
         n_bad++;
         $display("FAIL commit_old: digits=%h seen=%0d want 1234", dut.u_bcd.bcd, ok);
      end
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         step(1);
         if (dut.u_bcd.bcd !== 16'h1234 && dut.u_bcd.bcd !== 16'h5678) mixed++;
         if (conv_done) ok = 1'b1;
      end
      n_cmp++;
      if (!ok || dut.u_bcd.bcd !== 16'h5678) begin
         n_bad++;
         $display("FAIL commit_new: digits=%h seen=%0d want 5678", dut.u_bcd.bcd, ok);
      end
      n_cmp++;
      if (mixed != 0) begin
         n_bad++;
         $display("FAIL no_mixed_digits: %0d cycles with mixed digits want 0", mixed);
      end
      capture_scan();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (!cap_ok || cap_seg[k] !== exp_seg[k]) begin
            n_bad++;
            $display("FAIL scan_5678 digit%0d: seg=%h want %h", k, cap_seg[k], exp_seg[k]);
         end
      end
   endtask

   task automatic test_free_run();
      logic [3:0] prev;
      int wraps;
      int bad_onehot;
      int bad_order;
      wraps = 0;
      bad_onehot = 0;
      bad_order = 0;
      prev = anode;
      for (int c = 0; c < 160; c++) begin
         step(1);
         if ($countones(~anode) != 1) bad_onehot++;
         if (anode != prev) begin
            if (anode != {prev[2:0], prev[3]}) bad_order++;
            if (prev == 4'b0111) wraps++;
            prev = anode;
         end
      end
      n_cmp++;
      if (bad_onehot != 0) begin
         n_bad++;
         $display("FAIL one_anode_low: %0d cycles violated want 0", bad_onehot);
      end
      n_cmp++;
      if (bad_order != 0) begin
         n_bad++;
         $display("FAIL scan_order: %0d bad transitions want 0", bad_order);
      end
      n_cmp++;
      if (wraps < 9) begin
         n_bad++;
         $display("FAIL idx_wrap: %0d wraps 3->0 want >=9", wraps);
      end
   endtask

   initial begin
      test_reset();
      test_1234();
      test_8191();
      test_blanking();
      test_change_during_shift();
      test_free_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
